// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite display path.
//   pattern_info_t : pattern descriptor (base address, stored stride/rows,
//                    displayed width/height), 16 bits per field, MSB first.
//   sprite_info_t  : per-sprite placement (visible, hflip, x, y, reserved).
package sprite_pkg;

  localparam int ADDR_W = 16;  // pixel-memory address width
  localparam int POS_W  = 10;  // raster / sprite position width
  localparam int WIN_W  = 17;  // window-edge width, wide enough that x+act_h never wraps

  typedef struct packed {
    logic [15:0] append;  // base address of the pattern in pixel memory
    logic [15:0] res_h;   // stored row stride
    logic [15:0] res_v;   // stored rows (informational)
    logic [15:0] act_h;   // displayed width
    logic [15:0] act_v;   // displayed height
  } pattern_info_t;

  typedef struct packed {
    logic       visible;
    logic       hflip;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] rsvd;
  } sprite_info_t;

endpackage

// File: rtl/sprite_addr_cal.sv
// Per-sprite pixel address calculator.
// Compares the raster position against the sprite window and, on a hit,
// produces the pixel-memory address of the texel under the raster.
// Outputs are registered: one cycle of latency, no handshake.
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   pattern_info pattern descriptor (see sprite_pkg::pattern_info_t)
//   sprite_info  sprite placement   (see sprite_pkg::sprite_info_t)
//   hcount       current raster column
//   vcount       current raster row
//   addr_output  texel address, forced to 0 when not inside the sprite
//   valid        raster inside a visible sprite window
module sprite_addr_cal
  import sprite_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [79:0]       pattern_info,
  input  logic [31:0]       sprite_info,
  input  logic [POS_W-1:0]  hcount,
  input  logic [POS_W-1:0]  vcount,
  output logic [ADDR_W-1:0] addr_output,
  output logic              valid
);

  pattern_info_t     pat;
  sprite_info_t      spr;
  logic [WIN_W-1:0]  x_end;
  logic [WIN_W-1:0]  y_end;
  logic              h_in;
  logic              v_in;
  logic              hit;
  logic [POS_W-1:0]  dx;
  logic [POS_W-1:0]  dy;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr;
  logic              unused_bits;

  assign pat = pattern_info;
  assign spr = sprite_info;

  // res_v and the reserved sprite bits carry no function here.
  assign unused_bits = ^{pat.res_v, spr.rsvd};

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    x_end    = '0;
    y_end    = '0;
    h_in     = 1'b0;
    v_in     = 1'b0;
    hit      = 1'b0;
    dx       = '0;
    dy       = '0;
    col      = '0;
    row_base = '0;
    addr     = '0;

    // Window right/bottom edges are exclusive and computed at 17 bits, so a
    // sprite hanging off the right or bottom edge is clipped, not wrapped.
    x_end = WIN_W'(spr.x) + WIN_W'(pat.act_h);
    y_end = WIN_W'(spr.y) + WIN_W'(pat.act_v);
    h_in  = (hcount >= spr.x) && (WIN_W'(hcount) < x_end);
    v_in  = (vcount >= spr.y) && (WIN_W'(vcount) < y_end);
    hit   = spr.visible && h_in && v_in;

    // Offsets are only meaningful on a hit; off-window values are discarded.
    dx = hcount - spr.x;
    dy = vcount - spr.y;

    col      = spr.hflip ? (pat.act_h - ADDR_W'(1) - ADDR_W'(dx)) : ADDR_W'(dx);
    row_base = ADDR_W'(dy) * pat.res_h;  // truncated product, may map to a DSP
    addr     = pat.append + row_base + col;
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= 1'b0;
      addr_output <= '0;
    end else begin
      valid       <= hit;
      // A miss drives address 0 so downstream memory reads stay in range.
      addr_output <= hit ? addr : '0;
    end
  end

endmodule

// File: tb/tb_sprite_addr_cal.sv
module tb_sprite_addr_cal;

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [15:0] addr_output;
  logic        valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_addr_cal dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_info (pattern_info),
    .sprite_info  (sprite_info),
    .hcount       (hcount),
    .vcount       (vcount),
    .addr_output  (addr_output),
    .valid        (valid)
  );

  function automatic logic [79:0] mk_pat(int app, int rh, int rv, int ah, int av);
    return {app[15:0], rh[15:0], rv[15:0], ah[15:0], av[15:0]};
  endfunction

  function automatic logic [31:0] mk_spr(bit vis, bit hf, int x, int y, int rsvd = 0);
    return {vis, hf, x[9:0], y[9:0], rsvd[9:0]};
  endfunction

  // Reference model: straight from the address rules using plain integers.
  function automatic void model(input logic [79:0] p, input logic [31:0] s,
                                input logic [9:0] h, input logic [9:0] v,
                                output bit ev, output int ea);
    int app, rh, ah, av, x, y, hi, vi, col;
    bit vis, hf;
    app = int'(p[79:64]); rh = int'(p[63:48]);
    ah  = int'(p[31:16]); av = int'(p[15:0]);
    vis = s[31]; hf = s[30];
    x = int'(s[29:20]); y = int'(s[19:10]);
    hi = int'(h); vi = int'(v);
    ev = vis && hi >= x && hi < x + ah && vi >= y && vi < y + av;
    if (ev) begin
      col = hf ? (ah - 1 - (hi - x)) : (hi - x);
      ea  = (app + (vi - y) * rh + col) & 16'hFFFF;
    end else begin
      ea = 0;
    end
  endfunction

  task automatic drive(input logic [79:0] p, input logic [31:0] s,
                       input int h, input int v);
    pattern_info = p;
    sprite_info  = s;
    hcount       = h[9:0];
    vcount       = v[9:0];
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(mk_pat(0, 64, 64, 64, 64), mk_spr(1, 0, 100, 50), 110, 60);
    tick();
    total++;
    if (valid !== 1'b0 || addr_output !== 16'd0) begin
      bad++;
      $display("FAIL reset_state: valid=%b addr=%0d want valid=0 addr=0", valid, addr_output);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int hs[4] = '{100, 163, 164, 99};
    int vs[4] = '{50, 113, 113, 50};
    bit ev[4] = '{1, 1, 0, 0};
    int ea[4] = '{0, 4095, 0, 0};
    for (int i = 0; i < 4; i++) begin
      drive(mk_pat(0, 64, 64, 64, 64), mk_spr(1, 0, 100, 50), hs[i], vs[i]);
      tick();
      total++;
      if (valid !== ev[i] || addr_output !== 16'(ea[i])) begin
        bad++;
        $display("FAIL basic[%0d]: valid=%b addr=%0d want valid=%b addr=%0d",
                 i, valid, addr_output, ev[i], ea[i]);
      end
    end
  endtask

  task automatic test_hflip();
    int hs[2] = '{100, 163};
    int ea[2] = '{127, 64};
    for (int i = 0; i < 2; i++) begin
      drive(mk_pat(0, 64, 64, 64, 64), mk_spr(1, 1, 100, 50), hs[i], 51);
      tick();
      total++;
      if (valid !== 1'b1 || addr_output !== 16'(ea[i])) begin
        bad++;
        $display("FAIL hflip[%0d]: valid=%b addr=%0d want valid=1 addr=%0d",
                 i, valid, addr_output, ea[i]);
      end
    end
  endtask

  task automatic test_offset();
    int hs[3] = '{15, 16, 0};
    int vs[3] = '{2, 2, 0};
    bit ev[3] = '{1, 0, 1};
    int ea[3] = '{1079, 0, 1000};
    for (int i = 0; i < 3; i++) begin
      drive(mk_pat(1000, 32, 32, 16, 16), mk_spr(1, 0, 0, 0, 10'h3FF), hs[i], vs[i]);
      tick();
      total++;
      if (valid !== ev[i] || addr_output !== 16'(ea[i])) begin
        bad++;
        $display("FAIL offset[%0d]: valid=%b addr=%0d want valid=%b addr=%0d",
                 i, valid, addr_output, ev[i], ea[i]);
      end
    end
  endtask

  task automatic test_invisible();
    int hs[5] = '{100, 130, 100, 0, 200};
    int vs[5] = '{50, 80, 50, 0, 60};
    for (int i = 0; i < 5; i++) begin
      if (i < 2)
        drive(mk_pat(0, 64, 64, 64, 64), mk_spr(0, 0, 100, 50), hs[i], vs[i]);
      else
        drive(mk_pat(0, 64, 64, 0, 64), mk_spr(1, 0, 100, 50), hs[i], vs[i]);
      tick();
      total++;
      if (valid !== 1'b0 || addr_output !== 16'd0) begin
        bad++;
        $display("FAIL invisible[%0d]: valid=%b addr=%0d want valid=0 addr=0",
                 i, valid, addr_output);
      end
    end
  endtask

  task automatic test_reset_mid();
    // Inside the window at dx=20, dy=10 -> 10*64+20.
    drive(mk_pat(0, 64, 64, 64, 64), mk_spr(1, 0, 100, 50), 120, 60);
    tick();
    total++;
    if (valid !== 1'b1 || addr_output !== 16'd660) begin
      bad++;
      $display("FAIL reset_mid_pre: valid=%b addr=%0d want valid=1 addr=660", valid, addr_output);
    end
    reset = 1'b1;
    tick();
    total++;
    if (valid !== 1'b0 || addr_output !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid_hold: valid=%b addr=%0d want valid=0 addr=0", valid, addr_output);
    end
    reset = 1'b0;
    tick();
    total++;
    if (valid !== 1'b1 || addr_output !== 16'd660) begin
      bad++;
      $display("FAIL reset_mid_resume: valid=%b addr=%0d want valid=1 addr=660", valid, addr_output);
    end
  endtask

  task automatic test_wrap_and_clip();
    // Address sum wraps modulo 2^16.
    drive(mk_pat(16'hFFF0, 64, 64, 64, 64), mk_spr(1, 0, 0, 0), 32, 0);
    tick();
    total++;
    if (valid !== 1'b1 || addr_output !== 16'h0010) begin
      bad++;
      $display("FAIL wrap: valid=%b addr=%h want valid=1 addr=0010", valid, addr_output);
    end
    // Window past column/row 1023 is clipped, never wrapped around.
    drive(mk_pat(0, 64, 128, 64, 100), mk_spr(1, 0, 1000, 1000), 1023, 1023);
    tick();
    total++;
    if (valid !== 1'b1 || addr_output !== 16'd1495) begin
      bad++;
      $display("FAIL clip_edge: valid=%b addr=%0d want valid=1 addr=1495", valid, addr_output);
    end
    drive(mk_pat(0, 64, 128, 64, 100), mk_spr(1, 0, 1000, 1000), 10, 1010);
    tick();
    total++;
    if (valid !== 1'b0 || addr_output !== 16'd0) begin
      bad++;
      $display("FAIL clip_nowrap: valid=%b addr=%0d want valid=0 addr=0", valid, addr_output);
    end
  endtask

  task automatic test_back_to_back_random();
    logic [79:0] p;
    logic [31:0] s;
    int h, v, x, y, ah, av;
    bit ev;
    int ea;
    for (int i = 0; i < 400; i++) begin
      ah = $urandom_range(0, 120);
      av = $urandom_range(0, 120);
      x  = $urandom_range(0, 1023);
      y  = $urandom_range(0, 1023);
      p  = mk_pat($urandom_range(0, 65535), $urandom_range(0, 300),
                  $urandom_range(0, 300), ah, av);
      s  = mk_spr($urandom_range(0, 7) != 0, $urandom_range(0, 1), x, y,
                  $urandom_range(0, 1023));
      // Bias the raster around the window edges so hits and misses both occur.
      h  = (x + $urandom_range(0, ah + 2) - 1) & 10'h3FF;
      v  = (y + $urandom_range(0, av + 2) - 1) & 10'h3FF;
      drive(p, s, h, v);
      model(p, s, h[9:0], v[9:0], ev, ea);
      tick();
      total++;
      if (valid !== ev || addr_output !== 16'(ea)) begin
        bad++;
        $display("FAIL random[%0d]: valid=%b addr=%0d want valid=%b addr=%0d",
                 i, valid, addr_output, ev, ea);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    drive('0, '0, 0, 0);
    #2;
    test_reset();
    test_basic();
    test_hflip();
    test_offset();
    test_invisible();
    test_reset_mid();
    test_wrap_and_clip();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_addr_cal.md
Name:
sprite_addr_cal

Overview:
- Per-sprite pixel address calculator for the sprite display path; one instance per sprite buffer (ping/pong).
- Compares the current raster position (hcount, vcount) against the sprite's on-screen window.
- When the raster is inside a visible sprite, it produces the on-chip pixel-memory address of the texel to show and asserts valid.
- Downstream logic uses the address to index a colour-index memory and a palette.

Parameters:
- ADDR_W, 16, width of addr_output and of the internal address arithmetic.
- POS_W, 10, width of hcount, vcount and the sprite x/y fields.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- pattern_info  input  80  pattern descriptor: [79:64] append (base address), [63:48] res_h (stored row stride), [47:32] res_v (stored rows), [31:16] act_h (displayed width), [15:0] act_v (displayed height)
- sprite_info  input  32  [31] visible, [30] hflip, [29:20] x, [19:10] y, [9:0] reserved (ignored)
- hcount  input  10  current raster column
- vcount  input  10  current raster row
- addr_output  output  16  pixel memory address, registered
- valid  output  1  raster inside visible sprite window, registered

Behaviour:
- One clock, one clock domain. Reset is synchronous and active-high.
- Reset: valid=0 and addr_output=0 on the next clk edge. Reset overrides any hit computed in the same cycle.
- Latency: exactly 1 cycle. Outputs registered on posedge clk reflect the inputs sampled at that edge. There is no handshake; outputs update every cycle.
- Offsets: dx = hcount - x and dy = vcount - y.
- Window compares use 17-bit unsigned arithmetic, so x+act_h and y+act_v never wrap.
- hit = visible AND hcount >= x AND hcount < x+act_h AND vcount >= y AND vcount < y+act_v.
- act_h=0 or act_v=0 gives hit=0 always.
- A window extending past 1023 is simply clipped by the raster range.
- col = hflip ? (act_h-1-dx) : dx.
- addr = append + dy*res_h + col, computed modulo 2^16 (truncate the product and the sum to 16 bits).
- res_v is informational only. No clipping to res_v or to res_h is done; keeping act_h<=res_h and act_v<=res_v is the caller's responsibility.
- When hit=1: valid<=1 and addr_output<=addr.
- When hit=0: valid<=0 and addr_output<=0. The address is forced to 0 so that downstream memory reads stay in range.
- sprite_info[9:0] has no effect.
- All inputs may change every cycle, including mid-line and mid-sprite; the output simply tracks the inputs with 1-cycle delay.
- The multiply (10x16, truncated to 16) may map to a DSP block. It must close timing in a single cycle at the pixel clock.

Decomposition:
- Shared package sprite_pkg holds:
  - packed struct pattern_info_t (append, res_h, res_v, act_h, act_v, 16 bits each, MSB first);
  - packed struct sprite_info_t (visible, hflip, x[9:0], y[9:0], rsvd[9:0]);
  - constants ADDR_W and POS_W.
- No sub-module is needed. The window compare and the address math are small enough to live inline.

Test Plan:
- pattern {append 0, res_h 64, res_v 64, act_h 64, act_v 64}; sprite visible, hflip 0, x=100, y=50; hcount=100, vcount=50 -> 1 cycle later valid=1, addr_output=0.
- Same setup, hcount=163, vcount=113 -> valid=1, addr_output=4095. Then hcount=164 -> valid=0, addr_output=0. Then hcount=99 -> valid=0.
- Same setup with hflip=1: hcount=100, vcount=51 -> addr=64+63=127. hcount=163, vcount=51 -> addr=64.
- pattern {append 1000, res_h 32, res_v 32, act_h 16, act_v 16}; x=0, y=0; hcount=15, vcount=2 -> addr=1079, valid=1. hcount=16 -> valid=0.
- visible=0 with any raster position inside the window -> valid=0, addr_output=0. Setting act_h=0 -> valid=0 everywhere.
- Assert reset while the raster is inside the sprite -> next cycle valid=0, addr=0. Release reset -> the hit resumes after 1 cycle.
- Wrap check: append=0xFFF0, res_h 64, dx=0x20, dy=0 -> addr=0x0010.
